// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: two-wire ordered-transition receiver.
// Decodes symbols, assembles words, valid/ready output stage.
module rx_frame_decoder #(
   parameter  int DATA_W      = 8,
   parameter  int SYNC_STAGES = 2,
   parameter  int ERR_W       = 8,
   localparam int CW          = $clog2(DATA_W+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ZERO_IN,
   input  logic              ONE_IN,
   output logic              link_ack,
   output logic [DATA_W-1:0] out_data,
   output logic [CW-1:0]     out_nbits,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              in_frame,
   output logic              sym_x0,
   output logic              err,
   output logic [ERR_W-1:0]  err_count
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_Z1, ST_O1, ST_ZO, ST_OZ,
      ST_ZO_ODN, ST_ZO_ZDN, ST_OZ_ODN, ST_OZ_ZDN
   } st_e;

   typedef enum logic [2:0] {
      SYM_ZERO, SYM_ONE, SYM_FS, SYM_X0, SYM_FE, SYM_FD
   } sym_e;

   logic [SYNC_STAGES-1:0] zs_q, os_q;
   logic                   zp_q, op_q;
   logic                   z, o, zr, zf, orr, of, both, rise;

   st_e                    st_q, st_d;
   logic                   wait_q, wait_d;
   logic                   done, derr;
   sym_e                   dsym;

   logic                   pend_q, pend_d;
   sym_e                   psym_q;
   logic [DATA_W-1:0]      acc_q, acc_d, bit_acc;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   inf_q, inf_d;
   logic                   perr, px0;

   logic [DATA_W-1:0]      od_q, od_d;
   logic [CW-1:0]          on_q, on_d;
   logic                   ol_q, ol_d;
   logic                   ov_q, ov_d;
   logic                   err_q, x0_q;
   logic [ERR_W-1:0]       ec_q;
   logic                   free;

   assign z    = zs_q[SYNC_STAGES-1];
   assign o    = os_q[SYNC_STAGES-1];
   assign zr   = z & ~zp_q;
   assign zf   = ~z & zp_q;
   assign orr  = o & ~op_q;
   assign of   = ~o & op_q;
   assign both = (z ^ zp_q) & (o ^ op_q);
   assign rise = zr | orr;

   // Input synchronisers and previous-sample registers for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         zs_q <= '0;
         os_q <= '0;
         zp_q <= 1'b0;
         op_q <= 1'b0;
      end else begin
         zs_q <= {zs_q[SYNC_STAGES-2:0], ZERO_IN};
         os_q <= {os_q[SYNC_STAGES-2:0], ONE_IN};
         zp_q <= z;
         op_q <= o;
      end
   end

   // Decoder state; after any wire error we ignore the link until 00
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q   <= ST_IDLE;
         wait_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         wait_q <= wait_d;
      end
   end

   // Next-state decode from the order of rise/fall events
   always_comb begin
      st_d   = st_q;
      wait_d = wait_q;
      done   = 1'b0;
      derr   = 1'b0;
      dsym   = SYM_ZERO;
      if (rise && pend_q) begin
         derr   = 1'b1;
         wait_d = 1'b1;
         st_d   = ST_IDLE;
      end else if (wait_q) begin
         if (!z && !o) wait_d = 1'b0;
      end else if (both) begin
         derr   = 1'b1;
         wait_d = 1'b1;
         st_d   = ST_IDLE;
      end else begin
         unique case (st_q)
            ST_IDLE: begin
               if (zr)       st_d = ST_Z1;
               else if (orr) st_d = ST_O1;
            end
            ST_Z1: begin
               if (zf) begin
                  done = 1'b1;
                  dsym = SYM_ZERO;
                  st_d = ST_IDLE;
               end else if (orr) st_d = ST_ZO;
            end
            ST_O1: begin
               if (of) begin
                  done = 1'b1;
                  dsym = SYM_ONE;
                  st_d = ST_IDLE;
               end else if (zr) st_d = ST_OZ;
            end
            ST_ZO: begin
               if (of)      st_d = ST_ZO_ODN;
               else if (zf) st_d = ST_ZO_ZDN;
            end
            ST_OZ: begin
               if (of)      st_d = ST_OZ_ODN;
               else if (zf) st_d = ST_OZ_ZDN;
            end
            ST_ZO_ODN, ST_OZ_ODN: begin
               if (zf) begin
                  done = 1'b1;
                  dsym = (st_q == ST_ZO_ODN) ? SYM_FS : SYM_FE;
                  st_d = ST_IDLE;
               end else if (orr) begin
                  derr   = 1'b1;
                  wait_d = 1'b1;
                  st_d   = ST_IDLE;
               end
            end
            ST_ZO_ZDN, ST_OZ_ZDN: begin
               if (of) begin
                  done = 1'b1;
                  dsym = (st_q == ST_ZO_ZDN) ? SYM_X0 : SYM_FD;
                  st_d = ST_IDLE;
               end else if (zr) begin
                  derr   = 1'b1;
                  wait_d = 1'b1;
                  st_d   = ST_IDLE;
               end
            end
            default: st_d = ST_IDLE;
         endcase
      end
   end

   assign free    = !ov_q || out_ready;
   assign bit_acc = acc_q | (DATA_W'(psym_q == SYM_ONE) << cnt_q);

   // Symbol processing, stalled only when a word must load into a busy output
   always_comb begin
      pend_d = pend_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      inf_d  = inf_q;
      perr   = 1'b0;
      px0    = 1'b0;
      od_d   = od_q;
      on_d   = on_q;
      ol_d   = ol_q;
      ov_d   = ov_q & ~out_ready;
      if (pend_q) begin
         pend_d = 1'b0;
         unique case (psym_q)
            SYM_FS: begin
               perr  = inf_q;
               inf_d = 1'b1;
               acc_d = '0;
               cnt_d = '0;
            end
            SYM_ZERO, SYM_ONE: begin
               if (!inf_q) begin
                  perr = 1'b1;
               end else if (cnt_q != CW'(DATA_W-1)) begin
                  acc_d = bit_acc;
                  cnt_d = cnt_q + CW'(1);
               end else if (free) begin
                  od_d  = bit_acc;
                  on_d  = CW'(DATA_W);
                  ol_d  = 1'b0;
                  ov_d  = 1'b1;
                  acc_d = '0;
                  cnt_d = '0;
               end else begin
                  pend_d = 1'b1;
               end
            end
            SYM_FE: begin
               if (!inf_q) begin
                  perr = 1'b1;
               end else if (free) begin
                  od_d  = acc_q;
                  on_d  = cnt_q;
                  ol_d  = 1'b1;
                  ov_d  = 1'b1;
                  inf_d = 1'b0;
                  acc_d = '0;
                  cnt_d = '0;
               end else begin
                  pend_d = 1'b1;
               end
            end
            SYM_FD: begin
               perr  = !inf_q;
               inf_d = 1'b0;
               acc_d = '0;
               cnt_d = '0;
            end
            SYM_X0:  px0 = 1'b1;
            default: pend_d = 1'b0;
         endcase
      end
      if (done) pend_d = 1'b1;
   end

   // Pending symbol, frame accumulator and output register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= 1'b0;
         psym_q <= SYM_ZERO;
         acc_q  <= '0;
         cnt_q  <= '0;
         inf_q  <= 1'b0;
         od_q   <= '0;
         on_q   <= '0;
         ol_q   <= 1'b0;
         ov_q   <= 1'b0;
      end else begin
         pend_q <= pend_d;
         if (done) psym_q <= dsym;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         inf_q  <= inf_d;
         od_q   <= od_d;
         on_q   <= on_d;
         ol_q   <= ol_d;
         ov_q   <= ov_d;
      end
   end

   // Error / X0 pulses and saturating error counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
         x0_q  <= 1'b0;
         ec_q  <= '0;
      end else begin
         err_q <= derr | perr;
         x0_q  <= px0;
         if ((derr | perr) && ec_q != '1) ec_q <= ec_q + ERR_W'(1);
      end
   end

   assign link_ack  = pend_q;
   assign out_data  = od_q;
   assign out_nbits = on_q;
   assign out_last  = ol_q;
   assign out_valid = ov_q;
   assign in_frame  = inf_q;
   assign sym_x0    = x0_q;
   assign err       = err_q;
   assign err_count = ec_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// tb_rx_frame_decoder: random symbol traffic against a
// transaction-level model, plus directed literal checks.
module tb_rx_frame_decoder;
   localparam int DW = 8;
   localparam int SS = 2;
   localparam int EW = 3;
   localparam int NW = $clog2(DW+1);
   localparam int S_ZERO = 0, S_ONE = 1, S_FS = 2;
   localparam int S_X0 = 3, S_FE = 4, S_FD = 5;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [NW-1:0] n;
      logic          l;
   } wrd_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          zin = 1'b0, oin = 1'b0;
   logic          out_ready = 1'b0;
   logic          link_ack, out_last, out_valid;
   logic          in_frame, sym_x0, err;
   logic [DW-1:0] out_data;
   logic [NW-1:0] out_nbits;
   logic [EW-1:0] err_count;

   int   errors = 0, checks = 0;
   wrd_t expq[$];
   wrd_t acc_log[$];
   int   m_err = 0, m_x0 = 0, m_cnt = 0;
   bit   m_inf = 0;
   logic [DW-1:0] m_acc = '0;
   int   seen_err = 0, seen_x0 = 0;
   bit   rnd_rdy = 0;
   logic fix_rdy = 1'b1;

   rx_frame_decoder #(.DATA_W(DW), .SYNC_STAGES(SS), .ERR_W(EW)) dut (
      .clk(clk), .reset(reset), .ZERO_IN(zin), .ONE_IN(oin),
      .link_ack(link_ack), .out_data(out_data), .out_nbits(out_nbits),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .in_frame(in_frame), .sym_x0(sym_x0), .err(err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_log(input string nm, input int idx, input wrd_t exp);
      checks++;
      if (idx >= acc_log.size()) begin
         errors++;
         $display("FAIL %s: word %0d never delivered, want 0x%0h", nm, idx, exp);
      end else if (acc_log[idx] !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, acc_log[idx], exp);
      end
   endtask

   // Frame rules applied per symbol; yields expected words and counts
   task automatic model(input int s);
      case (s)
         S_FS: begin
            if (m_inf) m_err++;
            m_inf = 1; m_cnt = 0; m_acc = '0;
         end
         S_ZERO, S_ONE: begin
            if (!m_inf) m_err++;
            else begin
               m_acc[m_cnt] = (s == S_ONE);
               m_cnt++;
               if (m_cnt == DW) begin
                  expq.push_back({m_acc, NW'(DW), 1'b0});
                  m_cnt = 0; m_acc = '0;
               end
            end
         end
         S_FE: begin
            if (!m_inf) m_err++;
            else begin
               expq.push_back({m_acc, NW'(m_cnt), 1'b1});
               m_inf = 0; m_cnt = 0; m_acc = '0;
            end
         end
         S_FD: begin
            if (!m_inf) m_err++;
            m_inf = 0; m_cnt = 0; m_acc = '0;
         end
         default: m_x0++;
      endcase
   endtask

   task automatic wait_ack(input logic v, input int lim, input string nm);
      int n = 0;
      while (link_ack !== v && n < lim) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (link_ack !== v) begin
         errors++;
         $display("FAIL %s: link_ack got %b want %b after %0d cycles",
                  nm, link_ack, v, n);
      end
   endtask

   task automatic drv(input logic z, input logic o, input int hold);
      zin = z; oin = o;
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic send(input int s, input bit wf);
      logic [7:0] sq;
      int n;
      n = 4;
      case (s)
         S_ZERO:  begin sq = 8'b10_00_00_00; n = 2; end
         S_ONE:   begin sq = 8'b01_00_00_00; n = 2; end
         S_FS:    sq = 8'b10_11_10_00;
         S_X0:    sq = 8'b10_11_01_00;
         S_FE:    sq = 8'b01_11_10_00;
         default: sq = 8'b01_11_01_00;
      endcase
      wait_ack(1'b0, 600, "ack_idle");
      for (int i = 0; i < n - 1; i++)
         drv(sq[7-2*i], sq[6-2*i], $urandom_range(1, 3));
      drv(1'b0, 1'b0, 1);
      model(s);
      wait_ack(1'b1, 20, "ack_rise");
      if (wf) begin
         wait_ack(1'b0, 600, "ack_fall");
         chk("in_frame", in_frame, m_inf);
      end
   endtask

   task automatic both_rise();
      wait_ack(1'b0, 600, "ack_idle");
      drv(1'b1, 1'b1, 2);
      drv(1'b0, 1'b0, SS + 3);
      m_err++;
   endtask

   task automatic send_bits(input logic [DW-1:0] v, input int nb);
      for (int i = 0; i < nb; i++) send(v[i] ? S_ONE : S_ZERO, 1);
   endtask

   // Ready driver: random or fixed, applied after the main thread's updates
   initial forever begin
      @(posedge clk); #2;
      out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : fix_rdy;
   end

   // Per-cycle compare: hold stability, accepted words vs model, pulses
   initial begin
      bit   pstall;
      wrd_t pw, cw, e;
      pstall = 0;
      pw = '0;
      forever begin
         @(negedge clk);
         cw = {out_data, out_nbits, out_last};
         if (!reset) begin
            pstall = 0; seen_err = 0; seen_x0 = 0;
         end else begin
            if (err) seen_err++;
            if (sym_x0) seen_x0++;
            if (pstall) begin
               chk("hold_valid", out_valid, 1'b1);
               chk("hold_word", cw, pw);
            end
            if (out_valid && out_ready) begin
               acc_log.push_back(cw);
               if (expq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL word: got 0x%0h want none", cw);
               end else begin
                  e = expq.pop_front();
                  chk("word", cw, e);
               end
            end
            pstall = out_valid && !out_ready;
            pw = cw;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, r, sat;
      fix_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", link_ack, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_inframe", in_frame, 0);
      chk("rst_err", err, 0);
      chk("rst_errcnt", err_count, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      base = acc_log.size();
      send(S_FS, 1);
      send_bits(8'h4D, 8);
      send(S_FE, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("t1_nwords", acc_log.size() - base, 2);
      chk_log("t1_w0", base, {8'h4D, 4'd8, 1'b0});
      chk_log("t1_w1", base + 1, {8'h00, 4'd0, 1'b1});
      chk("t1_errcnt", err_count, 0);

      base = acc_log.size();
      send(S_FS, 1);
      send_bits(8'h03, 3);
      send(S_FE, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("t2_nwords", acc_log.size() - base, 1);
      chk_log("t2_w0", base, {8'h03, 4'd3, 1'b1});

      base = acc_log.size();
      send(S_FS, 1);
      send_bits(8'h15, 5);
      send(S_FD, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("t3_fd_nowords", acc_log.size() - base, 0);
      send(S_FS, 1);
      send_bits(8'hFF, 8);
      send(S_FD, 1);
      repeat (5) @(posedge clk);
      #1;
      chk_log("t3_w0", base, {8'hFF, 4'd8, 1'b0});

      send(S_ZERO, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("t4_zero_err", err_count, 1);
      both_rise();
      chk("t4_both_err", err_count, 2);
      send(S_X0, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("t4_x0_pulse", seen_x0, 1);
      chk("t4_x0_noerr", err_count, 2);

      fix_rdy = 1'b0;
      send(S_FS, 1);
      send_bits(8'hFF, 8);
      send_bits(8'h2A, 7);
      send(S_ONE, 0);
      repeat (8) @(posedge clk);
      #1;
      chk("t5_ack_held", link_ack, 1);
      chk("t5_valid", out_valid, 1);
      chk("t5_first", out_data, 8'hFF);
      drv(1'b1, 1'b0, 3);
      drv(1'b0, 1'b0, SS + 3);
      m_err++;
      chk("t5_rise_err", err_count, 3);
      chk("t5_ack_still", link_ack, 1);
      fix_rdy = 1'b1;
      wait_ack(1'b0, 10, "t5_ack_fall");
      chk("t5_valid2", out_valid, 1);
      chk("t5_second", out_data, 8'hAA);
      send(S_FE, 1);
      repeat (4) @(posedge clk);
      #1;

      rnd_rdy = 1;
      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 99);
         if (r < 35)      send(S_ZERO, 1);
         else if (r < 70) send(S_ONE, 1);
         else if (r < 78) send(S_FS, 1);
         else if (r < 86) send(S_FE, 1);
         else if (r < 91) send(S_FD, 1);
         else if (r < 96) send(S_X0, 1);
         else             both_rise();
      end
      rnd_rdy = 0;
      fix_rdy = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      sat = (m_err > 7) ? 7 : m_err;
      chk("rnd_drained", expq.size(), 0);
      chk("rnd_err_pulses", seen_err, m_err);
      chk("rnd_x0_pulses", seen_x0, m_x0);
      chk("rnd_errcnt_sat", err_count, sat);

      send(S_FS, 1);
      drv(1'b1, 1'b0, 2);
      drv(1'b1, 1'b1, 3);
      #3;
      reset = 1'b0;
      #1;
      chk("mid_ack", link_ack, 0);
      chk("mid_valid", out_valid, 0);
      chk("mid_inframe", in_frame, 0);
      chk("mid_errcnt", err_count, 0);
      chk("mid_data", out_data, 0);
      m_inf = 0; m_err = 0; m_cnt = 0; m_acc = '0;
      expq.delete();
      zin = 1'b0; oin = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send(S_ZERO, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_errcnt", err_count, 1);
      chk("post_rst_pulses", seen_err, m_err);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
